bus_arbiter: RTL and testbench
==============================

BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter Count, default 4: number of requesters sharing the OR-reduced bus; legal range 2..16.
REQ-002 Parameter Timeout, default 255: maximum BUSY cycles before a forced release; legal range 1..65535.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 req  input  Count  per-requester access request, level-sensitive.
REQ-006 done  input  1  shared resource signals completion of the current transaction; sampled only in BUSY.
REQ-007 grant  output  Count  one-hot grant; drives the per-source enable so at most one source presents non-zero data to the OR reducer.
REQ-008 grant_valid  output  1  high exactly when grant is non-zero.
REQ-009 grant_id  output  $clog2(Count)  binary index of the granted requester; 0 when grant_valid is low.
REQ-010 timeout  output  1  one-cycle pulse on a forced release.

Function
REQ-011 FSM states SHALL be IDLE, BUSY and RELEASE.
REQ-012 IDLE: if any req bit is set, the winner is the first set bit at or after rr_ptr, searching upward with wrap-around.
- grant, grant_id and grant_valid take the winner on the next edge.
- State goes to BUSY on that same edge.
- Latency from req to grant is 1 cycle.
REQ-013 IDLE with req all zero: outputs stay zero and rr_ptr is unchanged.
REQ-014 On entering BUSY, rr_ptr SHALL become winner+1 modulo Count.
REQ-015 BUSY: grant is held constant. Other req bits are ignored.
REQ-016 BUSY exit on done=1: go to RELEASE. grant and grant_valid clear on the same edge.
REQ-017 BUSY exit on req[granted]=0: go to RELEASE (abort). If done is also 1, treat it as a normal completion; the behaviour is identical.
REQ-018 BUSY cycle counter:
- Starts at 0 on BUSY entry.
- When it reaches Timeout-1 without done or abort, go to RELEASE and pulse timeout for 1 cycle.
- done or abort on that same cycle takes priority and suppresses timeout.
REQ-019 RELEASE SHALL last exactly one cycle with grant all zero, giving the OR-reduced bus one dead cycle, then return to IDLE.
- A requester cannot be re-granted sooner than 2 cycles after release.
REQ-020 grant SHALL never have more than one bit set in any cycle, including the cycle after reset.
REQ-021 A requester that keeps req high SHALL be granted within Count arbitration rounds (no starvation).
REQ-022 All outputs SHALL be driven from registers; there is no combinational path from req or done to any output.

Reset
REQ-023 While rst_n=0, all of the following SHALL hold:
- state=IDLE, grant=0, grant_valid=0, grant_id=0, timeout=0.
- rr_ptr=0 and cycle counter=0.
REQ-024 Reset asserted mid-BUSY SHALL drop grant asynchronously; no RELEASE cycle is produced.
REQ-025 After rst_n deasserts, the first grant SHALL be possible on the second rising edge.

Structure
REQ-026 A shared package SHALL hold:
- the state enum type (IDLE, BUSY, RELEASE);
- the default Timeout constant.
REQ-027 The round-robin priority pick SHALL be a sub-module rr_picker (inputs req and ptr; outputs one-hot and index).
- It is purely combinational.
- The top holds the FSM, rr_ptr and the cycle counter.

Verification
REQ-028 Single requester: req=4'b0100, done pulsed 3 cycles after grant -> grant=4'b0100 and grant_id=2 one cycle after req; 1 RELEASE cycle; grant re-asserts 2 cycles after done while req is still high.
REQ-029 Fairness: req=4'b1111 held, done every 2nd BUSY cycle -> grant_id sequence 0,1,2,3,0; rr_ptr wraps from 3 to 0.
REQ-030 Timeout: Timeout=8, req=4'b0001, done never asserted -> exactly 8 BUSY cycles, timeout high for 1 cycle, grant drops on the same edge.
REQ-031 Abort and collision: req[1] drops in BUSY -> RELEASE next edge with no timeout. done and the final timeout cycle coincide -> timeout stays 0.
REQ-032 Reset mid-BUSY: rst_n low for 1 cycle while grant=4'b1000 -> grant=0 immediately; after release with req=4'b1001, grant_id=0.
REQ-033 Assertions checked throughout all scenarios:
- grant is onehot0;
- grant_valid equals |grant;
- grant_id is consistent with grant.

Source files
------------

// File: rtl/bus_arbiter_pkg.sv
// Shared types and helpers for the round-robin bus arbiter.
// Included by the picker and the arbiter top.
package bus_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RELEASE
  } state_e;

  localparam int unsigned TIMEOUT_DEFAULT = 255;
  localparam int unsigned CNT_W = 16;

  function automatic int unsigned wrap_add(
    input int unsigned v,
    input int unsigned k,
    input int unsigned n
  );
    int unsigned s;
    s = v + k;
    return (s >= n) ? s - n : s;
  endfunction

endpackage

// File: rtl/bus_arbiter_picker.sv
// Combinational round-robin pick: first set req bit at or
// above ptr, wrapping around.
module rr_picker
  import bus_arbiter_pkg::*;
#(
  parameter int unsigned N = 4,
  localparam int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx
);

  logic          found;
  logic [IW-1:0] pos;

  always_comb begin
    onehot = '0;
    idx    = '0;
    found  = 1'b0;
    pos    = '0;
    for (int unsigned k = 0; k < N; k++) begin
      pos = IW'(wrap_add(32'(ptr), k, N));
      if (!found && req[pos]) begin
        found       = 1'b1;
        onehot[pos] = 1'b1;
        idx         = pos;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter for an OR-reduced shared bus with
// per-grant timeout and a dead cycle between owners.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int unsigned Count   = 4,
  parameter int unsigned Timeout = TIMEOUT_DEFAULT,
  localparam int unsigned IW     = $clog2(Count)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [Count-1:0] req,
  input  logic             done,
  output logic [Count-1:0] grant,
  output logic             grant_valid,
  output logic [IW-1:0]    grant_id,
  output logic             timeout
);

  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(Timeout - 1);

  state_e             state_q, state_d;
  logic [Count-1:0]   grant_q, grant_d;
  logic [IW-1:0]      gid_q, gid_d;
  logic               gvalid_q, gvalid_d;
  logic               to_q, to_d;
  logic [IW-1:0]      ptr_q, ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ready_q, ready_d;

  logic [Count-1:0]   pick_oh;
  logic [IW-1:0]      pick_idx;

  rr_picker #(
    .N (Count)
  ) u_picker (
    .req    (req),
    .ptr    (ptr_q),
    .onehot (pick_oh),
    .idx    (pick_idx)
  );

  // ready_q holds off arbitration for the first edge after reset
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    gid_d    = gid_q;
    gvalid_d = gvalid_q;
    to_d     = 1'b0;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    ready_d  = 1'b1;
    unique case (state_q)
      IDLE: begin
        if (ready_q && (|req)) begin
          state_d  = BUSY;
          grant_d  = pick_oh;
          gid_d    = pick_idx;
          gvalid_d = 1'b1;
          ptr_d    = IW'(wrap_add(32'(pick_idx), 1, Count));
          cnt_d    = '0;
        end
      end
      BUSY: begin
        if (done || !req[gid_q]) begin
          state_d  = RELEASE;
          grant_d  = '0;
          gid_d    = '0;
          gvalid_d = 1'b0;
        end else if (cnt_q == CNT_LAST) begin
          state_d  = RELEASE;
          grant_d  = '0;
          gid_d    = '0;
          gvalid_d = 1'b0;
          to_d     = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      RELEASE: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d  = IDLE;
        grant_d  = '0;
        gid_d    = '0;
        gvalid_d = 1'b0;
        cnt_d    = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      gid_q    <= '0;
      gvalid_q <= 1'b0;
      to_q     <= 1'b0;
      ptr_q    <= '0;
      cnt_q    <= '0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      gid_q    <= gid_d;
      gvalid_q <= gvalid_d;
      to_q     <= to_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      ready_q  <= ready_d;
    end
  end

  assign grant       = grant_q;
  assign grant_valid = gvalid_q;
  assign grant_id    = gid_q;
  assign timeout     = to_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: vector table plus
// timeout, collision and mid-grant reset sequences.
module tb_bus_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic       done;
  logic [3:0] grant;
  logic       grant_valid;
  logic [1:0] grant_id;
  logic       timeout;

  int passes = 0;
  int total  = 0;

  typedef struct packed {
    logic [3:0] req;
    logic       done;
    logic [3:0] g;
    logic [1:0] id;
    logic       v;
    logic       to;
  } vec_t;

  vec_t tv[$];

  bus_arbiter #(
    .Count   (4),
    .Timeout (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .done        (done),
    .grant       (grant),
    .grant_valid (grant_valid),
    .grant_id    (grant_id),
    .timeout     (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(
    input logic [3:0] r, input logic d,
    input logic [3:0] g, input logic [1:0] id,
    input logic v, input logic to
  );
    vec_t x;
    x.req = r; x.done = d; x.g = g;
    x.id = id; x.v = v; x.to = to;
    return x;
  endfunction

  task automatic cyc(input logic [3:0] r, input logic d);
    req  = r;
    done = d;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(
    input string nm,
    input logic [3:0] eg, input logic [1:0] ei,
    input logic ev, input logic et
  );
    total++;
    if ({grant, grant_id, grant_valid, timeout}
        === {eg, ei, ev, et}) begin
      passes++;
    end else begin
      $display("FAIL %s: got grant=%b id=%0d valid=%b to=%b, want grant=%b id=%0d valid=%b to=%b",
               nm, grant, grant_id, grant_valid, timeout,
               eg, ei, ev, et);
    end
  endtask

  task automatic chk_int(input string nm, input int got, input int want);
    total++;
    if (got == want) passes++;
    else $display("FAIL %s: got %0d, want %0d", nm, got, want);
  endtask

  // invariants checked on every falling edge
  always @(negedge clk) begin
    if (!$onehot0(grant)) begin
      total++;
      $display("FAIL onehot0: grant=%b", grant);
    end
    if (grant_valid !== (|grant)) begin
      total++;
      $display("FAIL valid_or: grant=%b valid=%b", grant, grant_valid);
    end
    if (grant_valid && (grant !== (4'b0001 << grant_id))) begin
      total++;
      $display("FAIL id_match: grant=%b id=%0d", grant, grant_id);
    end
    if (!grant_valid && (grant_id !== 2'd0)) begin
      total++;
      $display("FAIL id_zero: id=%0d, want 0", grant_id);
    end
  end

  initial begin
    int n;
    rst_n = 1'b0;
    req   = 4'b0000;
    done  = 1'b0;
    #1;
    chk("reset", 4'b0000, 2'd0, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("reset_hold", 4'b0000, 2'd0, 1'b0, 1'b0);
    rst_n = 1'b1;

    // first edge after reset cannot grant, second can
    cyc(4'b0100, 1'b0);
    chk("first_edge", 4'b0000, 2'd0, 1'b0, 1'b0);
    cyc(4'b0100, 1'b0);
    chk("req_to_grant", 4'b0100, 2'd2, 1'b1, 1'b0);

    tv.push_back(mk(4'b0100, 0, 4'b0100, 2'd2, 1, 0));
    tv.push_back(mk(4'b0100, 0, 4'b0100, 2'd2, 1, 0));
    tv.push_back(mk(4'b0100, 1, 4'b0000, 2'd0, 0, 0));
    tv.push_back(mk(4'b0100, 0, 4'b0000, 2'd0, 0, 0));
    tv.push_back(mk(4'b0100, 0, 4'b0100, 2'd2, 1, 0));
    tv.push_back(mk(4'b1111, 0, 4'b0100, 2'd2, 1, 0));
    tv.push_back(mk(4'b1111, 1, 4'b0000, 2'd0, 0, 0));
    tv.push_back(mk(4'b1111, 0, 4'b0000, 2'd0, 0, 0));
    tv.push_back(mk(4'b1111, 0, 4'b1000, 2'd3, 1, 0));
    tv.push_back(mk(4'b1111, 0, 4'b1000, 2'd3, 1, 0));
    tv.push_back(mk(4'b1111, 1, 4'b0000, 2'd0, 0, 0));
    tv.push_back(mk(4'b1111, 0, 4'b0000, 2'd0, 0, 0));
    tv.push_back(mk(4'b1111, 0, 4'b0001, 2'd0, 1, 0));
    tv.push_back(mk(4'b1111, 0, 4'b0001, 2'd0, 1, 0));
    tv.push_back(mk(4'b1111, 1, 4'b0000, 2'd0, 0, 0));
    tv.push_back(mk(4'b1111, 0, 4'b0000, 2'd0, 0, 0));
    tv.push_back(mk(4'b1111, 0, 4'b0010, 2'd1, 1, 0));
    tv.push_back(mk(4'b1111, 0, 4'b0010, 2'd1, 1, 0));
    tv.push_back(mk(4'b1111, 1, 4'b0000, 2'd0, 0, 0));
    tv.push_back(mk(4'b1111, 0, 4'b0000, 2'd0, 0, 0));
    tv.push_back(mk(4'b1111, 0, 4'b0100, 2'd2, 1, 0));
    tv.push_back(mk(4'b1111, 0, 4'b0100, 2'd2, 1, 0));
    tv.push_back(mk(4'b1111, 1, 4'b0000, 2'd0, 0, 0));
    tv.push_back(mk(4'b1111, 0, 4'b0000, 2'd0, 0, 0));
    tv.push_back(mk(4'b1111, 0, 4'b1000, 2'd3, 1, 0));
    tv.push_back(mk(4'b1111, 0, 4'b1000, 2'd3, 1, 0));
    tv.push_back(mk(4'b1111, 1, 4'b0000, 2'd0, 0, 0));
    tv.push_back(mk(4'b1111, 0, 4'b0000, 2'd0, 0, 0));
    tv.push_back(mk(4'b1111, 0, 4'b0001, 2'd0, 1, 0));
    tv.push_back(mk(4'b1111, 1, 4'b0000, 2'd0, 0, 0));
    tv.push_back(mk(4'b0000, 0, 4'b0000, 2'd0, 0, 0));
    tv.push_back(mk(4'b0000, 0, 4'b0000, 2'd0, 0, 0));
    tv.push_back(mk(4'b0010, 0, 4'b0010, 2'd1, 1, 0));
    tv.push_back(mk(4'b0010, 0, 4'b0010, 2'd1, 1, 0));
    tv.push_back(mk(4'b0000, 0, 4'b0000, 2'd0, 0, 0));
    tv.push_back(mk(4'b0000, 0, 4'b0000, 2'd0, 0, 0));

    foreach (tv[i]) begin
      cyc(tv[i].req, tv[i].done);
      chk($sformatf("vec%0d", i),
          tv[i].g, tv[i].id, tv[i].v, tv[i].to);
    end

    // timeout: ptr=2, only req[0] -> wraps to 0
    cyc(4'b0001, 1'b0);
    chk("to_grant", 4'b0001, 2'd0, 1'b1, 1'b0);
    n = 1;
    for (int i = 0; i < 20; i++) begin
      cyc(4'b0001, 1'b0);
      if (!grant_valid) break;
      n++;
    end
    chk_int("to_busy_cycles", n, 8);
    chk("to_pulse", 4'b0000, 2'd0, 1'b0, 1'b1);
    cyc(4'b0000, 1'b0);
    chk("to_pulse_end", 4'b0000, 2'd0, 1'b0, 1'b0);

    // done on the final timeout cycle wins
    cyc(4'b0010, 1'b0);
    chk("col_grant", 4'b0010, 2'd1, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) cyc(4'b0010, 1'b0);
    chk("col_last", 4'b0010, 2'd1, 1'b1, 1'b0);
    cyc(4'b0010, 1'b1);
    chk("col_done", 4'b0000, 2'd0, 1'b0, 1'b0);
    cyc(4'b0000, 1'b0);
    chk("col_after", 4'b0000, 2'd0, 1'b0, 1'b0);

    // reset while requester 3 owns the bus
    cyc(4'b1000, 1'b0);
    chk("rst_busy", 4'b1000, 2'd3, 1'b1, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    chk("rst_async", 4'b0000, 2'd0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc(4'b1001, 1'b0);
    chk("rst_first", 4'b0000, 2'd0, 1'b0, 1'b0);
    cyc(4'b1001, 1'b0);
    chk("rst_regrant", 4'b0001, 2'd0, 1'b1, 1'b0);

    cyc(4'b0000, 1'b0);
    cyc(4'b0000, 1'b0);
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
